// File: rtl/fp_norm_pack.sv
// Post-add normalise/pack stage: turns the mantissa adder's raw sum into a packed IEEE-754 single.
// Define FPU_NORM_ROUND_EN to round-to-nearest-even the bit discarded on the carry-out path.
module fp_norm_pack #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [MANT_W-1:0]       sum_i,
    input  logic                    of_i,
    input  logic [EXP_W-1:0]        exp_i,
    input  logic                    sign_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [EXP_W+MANT_W-1:0] result_o,
    output logic                    uf_o,
    output logic                    ovf_o
);
    localparam int RES_W = EXP_W + MANT_W;
    localparam logic [EXP_W:0]   EXP_INC = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;
    logic              sign_q;
    logic              resolved_q;
    logic              out_valid_q;
    logic              uf_q;
    logic              ovf_q;
    logic [RES_W-1:0]  result_q;

    logic [MANT_W-1:0] truncMant;
    logic [MANT_W-1:0] ofMant;
    logic [EXP_W:0]    ofExp;
    logic              ofOvf;
    logic              sumZero;

    assign truncMant = {1'b1, sum_i[MANT_W-1:1]};
    assign sumZero   = (sum_i == '0);

`ifdef FPU_NORM_ROUND_EN
    logic            roundUp;
    logic [MANT_W:0] rndMant;

    // One discarded bit is always an exact tie, so ties-to-even only looks at the kept LSB.
    assign roundUp = sum_i[0] & truncMant[0];
    assign rndMant = {1'b0, truncMant} + {{MANT_W{1'b0}}, roundUp};
    assign ofMant  = rndMant[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : rndMant[MANT_W-1:0];
    assign ofExp   = {1'b0, exp_i} + EXP_INC + {{EXP_W{1'b0}}, rndMant[MANT_W]};
`else
    assign ofMant  = truncMant;
    assign ofExp   = {1'b0, exp_i} + EXP_INC;
`endif

    // The extra exponent bit catches wrap-around as well as landing exactly on all-ones.
    assign ofOvf = (ofExp >= EXP_MAX);

    // Every accepted operand spends one SHIFT visit before DONE, so a k-shift result is ready k+1 edges after accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            resolved_q  <= 1'b0;
            out_valid_q <= 1'b0;
            uf_q        <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= SHIFT;
                        sign_q     <= sign_i;
                        uf_q       <= 1'b0;
                        ovf_q      <= 1'b0;
                        result_q   <= '0;
                        resolved_q <= 1'b0;
                        if (of_i) begin
                            mant_q <= ofMant;
                            exp_q  <= ofExp[EXP_W-1:0];
                            if (ofOvf) begin
                                ovf_q      <= 1'b1;
                                resolved_q <= 1'b1;
                                result_q   <= {sign_i, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                            end
                        end else if (sumZero) begin
                            mant_q     <= '0;
                            exp_q      <= '0;
                            resolved_q <= 1'b1;
                        end else begin
                            mant_q <= sum_i;
                            exp_q  <= exp_i;
                        end
                    end
                end
                SHIFT: begin
                    if (resolved_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else if (mant_q[MANT_W-1]) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= {sign_q, exp_q, mant_q[MANT_W-2:0]};
                    end else if (exp_q <= EXP_ONE) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        uf_q        <= 1'b1;
                        result_q    <= {sign_q, {(RES_W-1){1'b0}}};
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign uf_o        = uf_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed self-checking bench for fp_norm_pack with hand-computed expected results.
// Honours FPU_NORM_ROUND_EN for the rounding vector.
module tb_fp_norm_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [23:0] sumIn = '0;
    logic        ofIn = 1'b0;
    logic [7:0]  expIn = '0;
    logic        signIn = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;
    logic        uf;
    logic        ovf;

    int passCount  = 0;
    int checkCount = 0;
    int lat;
    int sawReady;

    fp_norm_pack #(.MANT_W(24), .EXP_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .sum_i       (sumIn),
        .of_i        (ofIn),
        .exp_i       (expIn),
        .sign_i      (signIn),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .result_o    (result),
        .uf_o        (uf),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand for exactly one accepting edge.
    task automatic applyStimulus(input logic [23:0] s, input logic o, input logic [7:0] e, input logic sg);
        int guard = 0;
        while (!inReady && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("accept_ready", {31'b0, inReady}, 32'd1);
        sumIn   = s;
        ofIn    = o;
        expIn   = e;
        signIn  = sg;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    // Counts edges after the accept edge until OUT_VALID; also records any IN_READY seen meanwhile.
    task automatic waitResult(output int cycles, output int readySeen);
        cycles    = 0;
        readySeen = inReady ? 1 : 0;
        do begin
            tick();
            cycles++;
            if (inReady) readySeen = 1;
        end while (!outValid && cycles < 60);
        checkOutput("out_valid_timeout", {31'b0, outValid}, 32'd1);
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("drain_valid_low", {31'b0, outValid}, 32'd0);
        checkOutput("drain_ready_high", {31'b0, inReady}, 32'd1);
    endtask

    task automatic runVector(input string tag, input logic [23:0] s, input logic o, input logic [7:0] e,
                             input logic sg, input logic [31:0] expRes, input logic expUf,
                             input logic expOvf, input int expLat);
        applyStimulus(s, o, e, sg);
        waitResult(lat, sawReady);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_uf"}, {31'b0, uf}, {31'b0, expUf});
        checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, expOvf});
    endtask

    initial begin
        logic [31:0] roundExp;
`ifdef FPU_NORM_ROUND_EN
        roundExp = 32'h41000000;
`else
        roundExp = 32'h40FFFFFF;
`endif

        // Reset state while reset is held
        tick();
        tick();
        checkOutput("rst_out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_uf", {31'b0, uf}, 32'd0);
        checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Carry-out single right shift
        runVector("of_path", 24'hC00000, 1'b1, 8'h80, 1'b0, 32'h40E00000, 1'b0, 1'b0, 1);
        releaseResult();

        // Worst-case 23 left shifts, IN_READY must stay low throughout
        runVector("deep_shift", 24'h000001, 1'b0, 8'h7F, 1'b0, 32'h34000000, 1'b0, 1'b0, 24);
        checkOutput("deep_shift_ready_low", sawReady, 0);
        releaseResult();

        // Four left shifts
        runVector("mid_shift", 24'h0C0000, 1'b0, 8'h85, 1'b0, 32'h40C00000, 1'b0, 1'b0, 5);
        releaseResult();

        // Already normal and zero inputs
        runVector("normal", 24'h800001, 1'b0, 8'h7F, 1'b1, 32'hBF800001, 1'b0, 1'b0, 1);
        releaseResult();
        runVector("zero", 24'h000000, 1'b0, 8'h55, 1'b1, 32'h00000000, 1'b0, 1'b0, 1);
        releaseResult();

        // Underflow: immediately and after some shifts
        runVector("uf_now", 24'h400000, 1'b0, 8'h01, 1'b1, 32'h80000000, 1'b1, 1'b0, 1);
        releaseResult();
        runVector("uf_late", 24'h000100, 1'b0, 8'h05, 1'b1, 32'h80000000, 1'b1, 1'b0, 5);
        releaseResult();

        // Overflow on carry-out with exponent reaching all-ones
        runVector("ovf", 24'h400000, 1'b1, 8'hFE, 1'b1, 32'hFF800000, 1'b0, 1'b1, 1);
        releaseResult();

        // Discarded-bit rounding (or truncation) with renormalising carry
        runVector("round", 24'hFFFFFF, 1'b1, 8'h80, 1'b0, roundExp, 1'b0, 1'b0, 1);
        releaseResult();

        // Backpressure: result held while a second operand is pulsed and ignored
        runVector("bp_first", 24'hC00000, 1'b1, 8'h80, 1'b0, 32'h40E00000, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            sumIn   = 24'h000001;
            ofIn    = 1'b0;
            expIn   = 8'h7F;
            signIn  = 1'b1;
            inValid = (i % 2 == 0);
            tick();
            checkOutput("bp_valid_held", {31'b0, outValid}, 32'd1);
            checkOutput("bp_result_held", result, 32'h40E00000);
            checkOutput("bp_ready_low", {31'b0, inReady}, 32'd0);
        end
        inValid = 1'b0;
        releaseResult();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_no_queued_op", {31'b0, outValid}, 32'd0);
        end
        runVector("bp_next", 24'h800001, 1'b0, 8'h7F, 1'b1, 32'hBF800001, 1'b0, 1'b0, 1);
        releaseResult();

        // Async reset while a result with a flag is held in DONE
        runVector("rst_done_pre", 24'h400000, 1'b0, 8'h01, 1'b1, 32'h80000000, 1'b1, 1'b0, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_done_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_done_result", result, 32'd0);
        checkOutput("rst_done_uf", {31'b0, uf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("rst_done_ready", {31'b0, inReady}, 32'd1);

        // Async reset mid-way through the deep shift, then a clean rerun
        applyStimulus(24'h000001, 1'b0, 8'h7F, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("rst_shift_busy", {31'b0, inReady}, 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_shift_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_shift_result", result, 32'd0);
        checkOutput("rst_shift_flags", {30'b0, uf, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("rst_shift_ready", {31'b0, inReady}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (outValid) break;
        end
        checkOutput("rst_shift_dropped", {31'b0, outValid}, 32'd0);
        runVector("rerun", 24'hC00000, 1'b1, 8'h80, 1'b0, 32'h40E00000, 1'b0, 1'b0, 1);
        releaseResult();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
